// File: rtl/reg_file_wr_arb.sv
// rtl/reg_file_wr_arb.sv - round-robin write-port arbiter and zero-sweep initialiser for reg_file
//
// Shares the single write port of the 32-entry register file between two
// requesters. Grants are combinational from req and arbiter state only; the
// register-file write port is driven from flops one cycle after the transfer.
// A transfer to register 0 is granted and consumed but never raises rf_wen.
//
// Optional feature macro: RF_CLEAR_EN
//   defined   - after every reset the arbiter writes zero to registers
//               1..31 (one per cycle) before granting anything; init_done
//               rises when the sweep has issued register 31.
//   undefined - no sweep state or counter; init_done is tied high and
//               grants are possible in the first cycle after reset.
//
// Ports:
//   clk                 clock, rising edge
//   rst                 asynchronous reset, active low
//   m0_req/addr/data    requester 0 write request, held stable until granted
//   m0_gnt              requester 0 grant (combinational)
//   m1_req/addr/data    requester 1 write request, held stable until granted
//   m1_gnt              requester 1 grant (combinational)
//   rf_wen              registered write enable to reg_file
//   rf_waddr            registered write address to reg_file
//   rf_wdata            registered write data to reg_file
//   init_done           high once requests can be granted

module reg_file_wr_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_data,
    output logic                  m0_gnt,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_data,
    output logic                  m1_gnt,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  init_done
);

    // Registered write port.
    logic                  rf_wen_q,   rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    // Requester granted on the most recent transfer (1 = m1). Resetting to 1
    // hands the first tie to m0.
    logic last_q, last_d;

    // High when the arbiter may grant requests.
    logic arb_en;

`ifdef RF_CLEAR_EN
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] CLR_FIRST = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  init_done_q, init_done_d;

    assign arb_en    = (state_q == ST_ARB);
    assign init_done = init_done_q;
`else
    assign arb_en    = 1'b1;
    assign init_done = 1'b1;
`endif

    // Grant selection: a lone requester always wins; on a tie the requester
    // that did not win the last transfer goes first.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (arb_en) begin
            if (m0_req && m1_req) begin
                if (last_q) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    // Next-state for the write port, round-robin pointer and sweep.
    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        last_d     = last_q;
`ifdef RF_CLEAR_EN
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
`endif

        // The grants already include req, so a grant here is a transfer.
        if (m0_gnt) begin
            rf_wen_d   = (m0_addr != '0);
            rf_waddr_d = m0_addr;
            rf_wdata_d = m0_data;
            last_d     = 1'b0;
        end else if (m1_gnt) begin
            rf_wen_d   = (m1_addr != '0);
            rf_waddr_d = m1_addr;
            rf_wdata_d = m1_data;
            last_d     = 1'b1;
        end

`ifdef RF_CLEAR_EN
        // Grants are forced low in CLEAR, so the sweep owns the port.
        if (state_q == ST_CLEAR) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = clr_cnt_q;
            rf_wdata_d = '0;
            clr_cnt_d  = clr_cnt_q + CLR_FIRST;
            if (&clr_cnt_q) begin
                state_d     = ST_ARB;
                init_done_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen_q    <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            last_q      <= 1'b1;
`ifdef RF_CLEAR_EN
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= CLR_FIRST;
            init_done_q <= 1'b0;
`endif
        end else begin
            rf_wen_q    <= rf_wen_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            last_q      <= last_d;
`ifdef RF_CLEAR_EN
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
`endif
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_reg_file_wr_arb.sv
// tb/tb_reg_file_wr_arb.sv - scoreboard testbench for reg_file_wr_arb
module tb_reg_file_wr_arb;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef RF_CLEAR_EN
    localparam int SWEEP = 31;
`else
    localparam int SWEEP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mreq [2];
    logic [AW-1:0] maddr[2];
    logic [DW-1:0] mdata[2];
    logic          m0_gnt, m1_gnt, rf_wen, init_done;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    reg_file_wr_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(mreq[0]), .m0_addr(maddr[0]), .m0_data(mdata[0]), .m0_gnt(m0_gnt),
        .m1_req(mreq[1]), .m1_addr(maddr[1]), .m1_data(mdata[1]), .m1_gnt(m1_gnt),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   cyc;
        bit            wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    int unsigned   cyc = 0;
    int unsigned   ready_cyc = 0;
    bit            m_last = 1'b1;
    bit            got[2];
    int            dut_log[$];
    logic [DW-1:0] rf_mem [32] = '{default: '0};
    logic [DW-1:0] ref_mem[32] = '{default: '0};
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_data = '0;
    exp_t          mon_e;

    // Behavioural register file fed by the DUT write port.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rf_wen && rf_waddr != '0) rf_mem[rf_waddr] <= rf_wdata;
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle out of reset, the write port must show either the
    // expected write tagged for this cycle or an idle port holding its values.
    always @(negedge clk) begin
        if (!rst) begin
            h_addr = '0;
            h_data = '0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_write: got none, wanted addr %0d data %0h at cycle %0d",
                         exp_q[0].addr, exp_q[0].data, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                chk("rf_wen", rf_wen, mon_e.wen);
                chk("rf_waddr", rf_waddr, mon_e.addr);
                chk("rf_wdata", rf_wdata, mon_e.data);
                h_addr = mon_e.addr;
                h_data = mon_e.data;
            end else begin
                chk("idle_rf_wen", rf_wen, 0);
                chk("idle_rf_waddr", rf_waddr, h_addr);
                chk("idle_rf_wdata", rf_wdata, h_data);
            end
        end
    end

    // One clock of stimulus: optionally release reset at the falling edge,
    // check grants against the reference rules, record transfers.
    task automatic tick(bit rel);
        bit e[2];
        @(negedge clk);
        if (rel) begin
            rst = 1'b1;
            ready_cyc = cyc + SWEEP;
            for (int a = 1; a <= SWEEP; a++) begin
                exp_q.push_back('{cyc + a, 1'b1, AW'(a), DW'(0)});
                ref_mem[a] = '0;
            end
        end
        #1;
        e[0] = 1'b0;
        e[1] = 1'b0;
        if (cyc >= ready_cyc) begin
            if (mreq[0] && mreq[1]) e[m_last ? 0 : 1] = 1'b1;
            else begin
                e[0] = mreq[0];
                e[1] = mreq[1];
            end
        end
        chk("m0_gnt", m0_gnt, e[0]);
        chk("m1_gnt", m1_gnt, e[1]);
        chk("init_done", init_done, cyc >= ready_cyc);
        if (m0_gnt) dut_log.push_back(0);
        if (m1_gnt) dut_log.push_back(1);
        got[0] = 1'b0;
        got[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (e[i]) begin
                got[i] = 1'b1;
                m_last = (i == 1);
                exp_q.push_back('{cyc + 1, maddr[i] != '0, maddr[i], mdata[i]});
                if (maddr[i] != '0) ref_mem[maddr[i]] = mdata[i];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(int i);
        mreq[i]  = 1'b1;
        maddr[i] = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
        mdata[i] = $urandom;
    endtask

    task automatic run(int n, bit rnd);
        for (int k = 0; k < n; k++) begin
            tick(1'b0);
            for (int i = 0; i < 2; i++) begin
                if (got[i]) mreq[i] = 1'b0;
                if (rnd && !mreq[i] && $urandom_range(0, 1) == 1) new_req(i);
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && (mreq[0] || mreq[1]); k++) run(1, 1'b0);
        chk("drain_done", {mreq[0], mreq[1]}, 0);
        run(2, 1'b0);
    endtask

    // Called just after a rising edge.
    task automatic assert_rst();
        rst = 1'b0;
        #1;
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_init_done", init_done, SWEEP == 0);
        exp_q.delete();
        m_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        while (cyc < ready_cyc + 1) run(1, 1'b0);
    endtask

    task automatic check_all_zero(string name);
        for (int a = 0; a < 32; a++) chk(name, rf_mem[a], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            mreq[i]  = 1'b0;
            maddr[i] = '0;
            mdata[i] = '0;
        end
        #1;
        chk("init_rf_wen", rf_wen, 0);
        chk("init_rf_waddr", rf_waddr, 0);
        chk("init_rf_wdata", rf_wdata, 0);
        chk("init_init_done", init_done, SWEEP == 0);
        repeat (2) @(posedge clk);
        #1;
        tick(1'b1);
        wait_ready();

        // Round-robin: both hold req for four grants.
        dut_log.delete();
        for (int i = 0; i < 2; i++) begin
            new_req(i);
            maddr[i] = AW'($urandom_range(1, 31));
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0);
            for (int i = 0; i < 2; i++) begin
                if (got[i]) begin
                    if (k < 2) begin
                        maddr[i] = AW'($urandom_range(1, 31));
                        mdata[i] = $urandom;
                    end else mreq[i] = 1'b0;
                end
            end
        end
        chk("rr_count", dut_log.size(), 4);
        for (int k = 0; k < 4 && k < dut_log.size(); k++) chk("rr_order", dut_log[k], k % 2);
        drain();

        // Single requester to address 5.
        mreq[0] = 1'b1; maddr[0] = 5; mdata[0] = 32'hDEADBEEF;
        drain();
        chk("reg5", rf_mem[5], 32'hDEADBEEF);

        // Address 0 from m1 is consumed without a write.
        mreq[1] = 1'b1; maddr[1] = 0; mdata[1] = 32'hFFFFFFFF;
        drain();
        chk("reg0", rf_mem[0], 0);

        // Same-address collision.
        dut_log.delete();
        mreq[0] = 1'b1; maddr[0] = 9; mdata[0] = 32'h11;
        mreq[1] = 1'b1; maddr[1] = 9; mdata[1] = 32'h22;
        drain();
        chk("coll_count", dut_log.size(), 2);
        for (int k = 0; k < 2 && k < dut_log.size(); k++) chk("coll_order", dut_log[k], k);
        chk("reg9", rf_mem[9], 32'h22);

        // Randomised traffic, including back-to-back requests and address 0.
        run(400, 1'b1);
        drain();

`ifdef RF_CLEAR_EN
        // Full sweep with m0 requesting throughout.
        assert_rst();
        mreq[0] = 1'b1; maddr[0] = 7; mdata[0] = $urandom;
        tick(1'b1);
        wait_ready();
        check_all_zero("sweep_zero");
        drain();

        // Reset at sweep address 12, then a complete restart.
        assert_rst();
        tick(1'b1);
        while (cyc < ready_cyc - 19) run(1, 1'b0);
        chk("mid_rf_wen", rf_wen, 1);
        chk("mid_rf_waddr", rf_waddr, 12);
        assert_rst();
        tick(1'b1);
        wait_ready();
        check_all_zero("resweep_zero");
`else
        // Reset with a request pending: granted in the first cycle after release.
        assert_rst();
        new_req(1);
        tick(1'b1);
        if (got[1]) mreq[1] = 1'b0;
        drain();
`endif
        run(100, 1'b1);
        drain();

        chk("queue_empty", exp_q.size(), 0);
        for (int a = 0; a < 32; a++) chk("final_reg", rf_mem[a], ref_mem[a]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
